// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared seven-segment digit codes (active-low, gfedcba) and the
//            blank pattern used by the parking display.
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t c_seg_blank = 7'b1111111;

    function automatic seg_t seg_encode(input logic [3:0] digit);
        seg_t code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = c_seg_blank;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_debounce.sv
`default_nettype none
// ============================================================================
// Module   : slot_debounce
// Purpose  : One occupancy channel: 2-flop synchroniser, stability counter and
//            filtered occupancy bit.
// Revision : 1.0 - initial release
// ============================================================================
module slot_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic car_raw,
    output logic filt
);
    import parking_pkg::*;

    localparam logic [7:0] c_deb_last = 8'(DEB_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_cnt;
    logic       r_filt;

    // The counter only advances while the synchronised input disagrees with the
    // filtered bit; any agreement (including a reverted glitch) restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= 8'd0;
            r_filt  <= 1'b0;
        end else begin
            r_sync1 <= car_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_filt) begin
                if (r_cnt == c_deb_last) begin
                    r_filt <= r_sync2;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/parking_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : parking_display_mux
// Purpose  : Debounced parking occupancy counter with a two-digit multiplexed
//            seven-segment display and full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module parking_display_mux #(
    parameter int SLOTS       = 16,
    parameter int DEB_CYCLES  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SLOTS-1:0] car,
    output logic [6:0]       seg,
    output logic [7:0]       AN,
    output logic [6:0]       count,
    output logic             full,
    output logic             empty
);
    import parking_pkg::*;

    localparam int             c_rw           = $clog2(REFRESH_DIV);
    localparam logic [c_rw-1:0] c_refresh_last = c_rw'(REFRESH_DIV - 1);

    logic [SLOTS-1:0] w_filt;
    logic [6:0]       w_pop;
    logic [6:0]       w_rem;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;

    logic [6:0]      r_count;
    logic            r_full;
    logic            r_empty;
    logic [c_rw-1:0] r_refresh;
    logic            r_idx;
    seg_t            r_seg;
    logic [7:0]      r_an;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            slot_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .car_raw(car[gi]),
                .filt   (w_filt[gi])
            );
        end
    endgenerate

    always_comb begin
        w_pop = 7'd0;
        for (int i = 0; i < SLOTS; i++) begin
            w_pop = w_pop + 7'(w_filt[i]);
        end
    end

    // Nine compare-subtract stages cover the whole 0..99 range.
    always_comb begin
        w_rem  = r_count;
        w_tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (w_rem >= 7'd10) begin
                w_rem  = w_rem - 7'd10;
                w_tens = w_tens + 4'd1;
            end
        end
        w_ones = 4'(w_rem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 7'd0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_pop;
            r_full  <= (w_pop == 7'(SLOTS));
            r_empty <= (w_pop == 7'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= 1'b0;
        end else if (r_refresh == c_refresh_last) begin
            r_refresh <= '0;
            r_idx     <= ~r_idx;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // seg and AN share one register stage so they never disagree on the digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_seg_blank;
            r_an  <= 8'hFF;
        end else if (r_idx) begin
            r_seg <= (w_tens == 4'd0) ? c_seg_blank : seg_encode(w_tens);
            r_an  <= 8'b1111_1101;
        end else begin
            r_seg <= seg_encode(w_ones);
            r_an  <= 8'b1111_1110;
        end
    end

    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;
    assign seg   = r_seg;
    assign AN    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_parking_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_display_mux
// Purpose  : Directed self-checking bench for parking_display_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_display_mux;

    localparam int c_slots = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [c_slots-1:0] car;
    logic [6:0]         seg;
    logic [7:0]         AN;
    logic [6:0]         count;
    logic               full;
    logic               empty;

    int n_checks = 0;
    int n_fail   = 0;

    parking_display_mux #(
        .SLOTS      (c_slots),
        .DEB_CYCLES (4),
        .REFRESH_DIV(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .car  (car),
        .seg  (seg),
        .AN   (AN),
        .count(count),
        .full (full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Samples seg while the requested anode is active; returns X on timeout.
    task automatic wait_an(input logic [7:0] target, output logic [6:0] s);
        s = 7'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (AN === target) begin
                s = seg;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        car   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        n_checks++; if (AN !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %b want 11111111", AN); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (AN !== 8'b11111110) begin n_fail++; $display("FAIL reset_first_an: got %b want 11111110", AN); end
    endtask

    task automatic test_glitch;
        @(posedge clk); #1;
        car = 16'h0008;
        repeat (3) @(posedge clk);
        #1 car = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL glitch_count cyc %0d: got %0d want 0", i, count); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL glitch_full: got %b want 0", full); end
    endtask

    task automatic test_fill_low;
        logic [6:0] s;
        @(posedge clk); #1;
        car = 16'h00FF;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL fill_early: got %0d want 0", count); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", count); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b want 0", full); end
        wait_an(8'b11111110, s);
        n_checks++; if (s !== 7'b0000000) begin n_fail++; $display("FAIL fill_ones_seg: got %b want 0000000", s); end
        wait_an(8'b11111101, s);
        n_checks++; if (s !== 7'b1111111) begin n_fail++; $display("FAIL fill_tens_blank: got %b want 1111111", s); end
    endtask

    task automatic test_all_full;
        logic [6:0] s;
        @(posedge clk); #1;
        car = 16'hFFFF;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", count); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", empty); end
        wait_an(8'b11111101, s);
        n_checks++; if (s !== 7'b1111001) begin n_fail++; $display("FAIL full_tens_seg: got %b want 1111001", s); end
        wait_an(8'b11111110, s);
        n_checks++; if (s !== 7'b0000010) begin n_fail++; $display("FAIL full_ones_seg: got %b want 0000010", s); end
        @(posedge clk); #1;
        car = 16'h0000;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL clear_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clear_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL clear_full: got %b want 0", full); end
    endtask

    task automatic test_refresh;
        logic [7:0] a [24];
        int         j;
        logic [7:0] first;
        logic [7:0] second;
        logic [7:0] exp_an;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a[i] = AN;
            n_checks++; if (AN[7:2] !== 6'h3F) begin n_fail++; $display("FAIL refresh_an_high cyc %0d: got %b want 111111", i, AN[7:2]); end
        end
        j = 1;
        while (j < 5 && a[j] === a[j-1]) j++;
        first  = a[j];
        second = a[j-1];
        n_checks++;
        if (!((first === 8'b11111110 && second === 8'b11111101) ||
              (first === 8'b11111101 && second === 8'b11111110))) begin
            n_fail++; $display("FAIL refresh_pair: got %b then %b want 11111110/11111101 alternation", second, first);
        end
        for (int i = j; i < j + 16; i++) begin
            exp_an = (((i - j) / 4) % 2 == 0) ? first : second;
            n_checks++; if (a[i] !== exp_an) begin n_fail++; $display("FAIL refresh_period cyc %0d: got %b want %b", i, a[i], exp_an); end
        end
    endtask

    task automatic test_mid_reset;
        @(posedge clk); #1;
        car = 16'h001F;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd5) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        @(posedge clk); #1;
        car = 16'h003F;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_full: got %b want 0", full); end
        n_checks++; if (seg !== 7'b1111111) begin n_fail++; $display("FAIL mid_rst_seg: got %b want 1111111", seg); end
        n_checks++; if (AN !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_an: got %b want 11111111", AN); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL mid_post_count cyc %0d: got %0d want 0", i, count); end
            if (i == 0) begin
                n_checks++; if (AN !== 8'b11111110) begin n_fail++; $display("FAIL mid_post_an: got %b want 11111110", AN); end
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 7'd6) begin n_fail++; $display("FAIL mid_refilter_count: got %0d want 6", count); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_fill_low();
        test_all_full();
        test_refresh();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
